// File: rtl/seg_marquee_scan.sv
// ---------------------------------------------------------------------------
// seg_marquee_scan
//   Multi-bank 7-segment scan driver with a writable character buffer and an
//   optional scrolling (marquee) presentation. The player control logic writes
//   segment patterns into the buffer, sets the message length and selects
//   static or scrolling mode. This block multiplexes the digits onto the
//   board segment/anode pins.
//
// Ports
//   i_clk       system clock
//   i_reset     asynchronous, active-low reset
//   i_en        display enable; 0 blanks every output on the next clock
//   i_scroll    0 static, 1 marquee
//   i_wr_en     buffer write strobe (one entry per cycle it is high)
//   i_wr_addr   buffer write index; indices >= MSG_DEPTH are ignored
//   i_wr_data   {dot,a,b,c,d,e,f,g} pattern to store
//   i_len_load  strobe: latch min(i_msg_len, MSG_DEPTH) as the message length
//   i_msg_len   message length in characters
//   o_seg       bank b pattern on [8b+7:8b]
//   o_an        active-high digit select, o_an[p] drives position p
//   o_disp_on   1 while enabled and driving the display
//
// Strobe semantics: i_wr_en and i_len_load are single-cycle qualifiers with no
// back-pressure; whatever is present on the data inputs at a rising edge with
// the strobe high is taken, and the effect is visible from the next cycle.
//
// All outputs are registered and reflect the scan index, offset and buffer
// contents of the previous cycle.
// ---------------------------------------------------------------------------
module seg_marquee_scan #(
    parameter  int BANKS        = 2,
    parameter  int DIG_PER_BANK = 4,
    parameter  int MSG_DEPTH    = 16,
    parameter  int REFRESH_DIV  = 200000,
    parameter  int SCROLL_DIV   = 50000000,
    localparam int ND           = BANKS * DIG_PER_BANK,
    localparam int AW           = $clog2(MSG_DEPTH),
    localparam int LW           = AW + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_scroll,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [7:0]         i_wr_data,
    input  logic               i_len_load,
    input  logic [LW-1:0]      i_msg_len,
    output logic [8*BANKS-1:0] o_seg,
    output logic [ND-1:0]      o_an,
    output logic               o_disp_on
);

    localparam int IW = (DIG_PER_BANK > 1) ? $clog2(DIG_PER_BANK) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int CW = $clog2(SCROLL_DIV);
    // Wide enough for offset + position + message length without overflow.
    localparam int SW = $clog2(ND + 2 * MSG_DEPTH) + 1;

    logic [7:0]         r_buf [MSG_DEPTH];
    logic [LW-1:0]      r_len;
    logic [AW-1:0]      r_off;
    logic [RW-1:0]      r_rcnt;
    logic [CW-1:0]      r_scnt;
    logic [IW-1:0]      r_idx;
    logic [8*BANKS-1:0] r_seg;
    logic [ND-1:0]      r_an;
    logic               r_disp_on;

    logic               w_tick;
    logic               w_marq;
    logic               w_addr_ok;
    logic [LW-1:0]      w_len_in;
    logic [8*BANKS-1:0] w_seg;
    logic [ND-1:0]      w_an;

    assign w_tick   = (r_rcnt == RW'(REFRESH_DIV - 1));
    // Scrolling only makes sense when the text is longer than the display.
    assign w_marq   = i_scroll && (SW'(r_len) > SW'(ND));
    assign w_len_in = (i_msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : i_msg_len;

    generate
        if ((2 ** AW) == MSG_DEPTH) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_part
            assign w_addr_ok = (i_wr_addr < AW'(MSG_DEPTH));
        end
    endgenerate

    // Refresh divider and scan index run regardless of i_en so the scan
    // phase is continuous across blanking.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rcnt <= '0;
            r_idx  <= '0;
        end else begin
            if (w_tick) begin
                r_rcnt <= '0;
                r_idx  <= (r_idx == IW'(DIG_PER_BANK - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    // Message length, scroll divider and marquee offset. A length load wins
    // over a scroll step in the same cycle; leaving marquee mode (scroll low
    // or short text) parks the offset and divider at 0 so the next marquee
    // start is aligned.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_len  <= '0;
            r_off  <= '0;
            r_scnt <= '0;
        end else if (i_len_load) begin
            r_len  <= w_len_in;
            r_off  <= '0;
            r_scnt <= '0;
        end else if (!w_marq) begin
            r_off  <= '0;
            r_scnt <= '0;
        end else if (r_scnt == CW'(SCROLL_DIV - 1)) begin
            r_scnt <= '0;
            r_off  <= ({1'b0, r_off} + LW'(1) == r_len) ? '0 : r_off + 1'b1;
        end else begin
            r_scnt <= r_scnt + 1'b1;
        end
    end

    // Character buffer. Display reads below use the pre-edge contents, so a
    // same-cycle write to the entry being shown returns the old value.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_wr_en && w_addr_ok) begin
            r_buf[i_wr_addr] <= i_wr_data;
        end
    end

    // Per-bank character selection and anode pattern.
    always_comb begin
        logic [SW-1:0] w_pos;
        logic [SW-1:0] w_sum;
        w_seg = '0;
        w_an  = '0;
        w_pos = '0;
        w_sum = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_pos = SW'(b * DIG_PER_BANK) + SW'(r_idx);
            w_sum = SW'(r_off) + w_pos;
            // In marquee mode len > ND and offset < len, so offset+pos is
            // below 2*len and a single conditional subtract is the modulo.
            if (w_sum >= SW'(r_len)) begin
                w_sum = w_sum - SW'(r_len);
            end
            if (r_len == '0) begin
                w_seg[8*b +: 8] = 8'h00;
            end else if (w_marq) begin
                w_seg[8*b +: 8] = r_buf[w_sum[AW-1:0]];
            end else if (w_pos < SW'(r_len)) begin
                w_seg[8*b +: 8] = r_buf[w_pos[AW-1:0]];
            end
        end
        for (int q = 0; q < ND; q++) begin
            w_an[q] = (IW'(q % DIG_PER_BANK) == r_idx);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_seg     <= '0;
            r_an      <= '0;
            r_disp_on <= 1'b0;
        end else if (i_en) begin
            r_seg     <= w_seg;
            r_an      <= w_an;
            r_disp_on <= 1'b1;
        end else begin
            r_seg     <= '0;
            r_an      <= '0;
            r_disp_on <= 1'b0;
        end
    end

    assign o_seg     = r_seg;
    assign o_an      = r_an;
    assign o_disp_on = r_disp_on;

endmodule

// File: tb/tb_seg_marquee_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_marquee_scan
//   Directed bench for seg_marquee_scan (2 banks x 4 digits, 16-entry buffer,
//   refresh every 4 clocks, scroll step every 64 clocks). The driver schedules
//   hand-computed {seg, an, disp_on} values for specific cycles after reset
//   release; the monitor pops and compares them as the cycles arrive.
// ---------------------------------------------------------------------------
module tb_seg_marquee_scan;

    localparam int BANKS = 2;
    localparam int DPB   = 4;
    localparam int DEPTH = 16;
    localparam int RDIV  = 4;
    localparam int SDIV  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        scroll;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        len_load;
    logic [4:0]  msg_len;
    logic [15:0] seg;
    logic [7:0]  an;
    logic        disp_on;

    int unsigned cyc;
    int          total = 0;
    int          bad   = 0;

    // {cycle[31:0], seg[15:0], an[7:0], disp_on}
    logic [56:0] exp_q[$];
    string       name_q[$];
    logic [56:0] mon_e;
    string       mon_nm;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Cycle n = number of rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    seg_marquee_scan #(
        .BANKS(BANKS), .DIG_PER_BANK(DPB), .MSG_DEPTH(DEPTH),
        .REFRESH_DIV(RDIV), .SCROLL_DIV(SDIV)
    ) dut (
        .i_clk(clk),
        .i_reset(rst_n),
        .i_en(en),
        .i_scroll(scroll),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_len_load(len_load),
        .i_msg_len(msg_len),
        .o_seg(seg),
        .o_an(an),
        .o_disp_on(disp_on)
    );

    // Output registered at edge n shows the scan index held before edge n.
    function automatic int unsigned exp_idx(input int unsigned n);
        return ((n - 1) / RDIV) % DPB;
    endfunction

    function automatic int unsigned next_at(input int unsigned from, input int unsigned k);
        int unsigned n;
        n = from;
        while (exp_idx(n) != k) n++;
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic expect_at(input int unsigned n, input logic [15:0] s,
                             input logic [7:0] a, input logic on, input string nm);
        exp_q.push_back({n, s, a, on});
        name_q.push_back(nm);
    endtask

    task automatic wait_cyc(input int unsigned n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) begin
            total++;
            bad++;
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, n);
        end
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load(input logic [4:0] l);
        len_load = 1'b1;
        msg_len  = l;
        @(negedge clk);
        len_load = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0][56:25] <= cyc) begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                total++;
                if (mon_e[56:25] != cyc) begin
                    bad++;
                    $display("FAIL %s: slot %0d passed, now cycle %0d", mon_nm, mon_e[56:25], cyc);
                end else if ({seg, an, disp_on} !== mon_e[24:0]) begin
                    bad++;
                    $display("FAIL %s @%0d: seg=%h an=%h on=%b required seg=%h an=%h on=%b",
                             mon_nm, cyc, seg, an, disp_on, mon_e[24:9], mon_e[8:1], mon_e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int unsigned n;
        int unsigned c;
        int unsigned c5;
        int unsigned m;

        rst_n = 1'b0; en = 1'b0; scroll = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; len_load = 1'b0; msg_len = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a scan (index 2).
        rst_n = 1'b1;
        en    = 1'b1;
        expect_at(9, 16'h0000, 8'h44, 1'b1, "scan_idx2");
        wait_cyc(9);
        rst_n = 1'b0;
        #1;
        total++;
        if ({seg, an, disp_on} !== 25'h0) begin
            bad++;
            $display("FAIL async_reset: seg=%h an=%h on=%b required all 0", seg, an, disp_on);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(1, 16'h0000, 8'h11, 1'b1, "post_reset_idx0");
        expect_at(5, 16'h0000, 8'h22, 1'b1, "post_reset_idx1");

        // Static text, length 4: bank 1 positions are beyond the text.
        write(4'd0, 8'h49);
        write(4'd1, 8'h0F);
        write(4'd2, 8'h77);
        write(4'd3, 8'h46);
        load(5'd4);
        n = next_at(cyc + 2, 0); expect_at(n, 16'h0049, 8'h11, 1'b1, "static_idx0");
        n = next_at(n, 1);       expect_at(n, 16'h000F, 8'h22, 1'b1, "static_idx1");
        n = next_at(n, 2);       expect_at(n, 16'h0077, 8'h44, 1'b1, "static_idx2");
        n = next_at(n, 3);       expect_at(n, 16'h0046, 8'h88, 1'b1, "static_idx3");
        wait_cyc(n);

        // Scroll requested but text (5) shorter than display: no stepping.
        scroll = 1'b1;
        write(4'd4, 8'h3F);
        load(5'd5);
        n = next_at(cyc + 2, 0); expect_at(n, 16'h3F49, 8'h11, 1'b1, "short_idx0");
        n = next_at(n, 1);       expect_at(n, 16'h000F, 8'h22, 1'b1, "short_idx1");
        n = next_at(n, 2);       expect_at(n, 16'h0077, 8'h44, 1'b1, "short_idx2");
        n = next_at(n, 3);       expect_at(n, 16'h0046, 8'h88, 1'b1, "short_idx3");
        n = next_at(n + SDIV + 8, 0);
        expect_at(n, 16'h3F49, 8'h11, 1'b1, "short_hold");
        wait_cyc(n);

        // Marquee, length 10, buf[i] = i+1. Step s is visible from c+2+64*s.
        for (int i = 0; i < 10; i++) write(4'(i), 8'(i + 1));
        c = cyc;
        load(5'd10);
        n = next_at(c + 2, 0);   expect_at(n, 16'h0501, 8'h11, 1'b1, "marq_off0");
        n = next_at(c + 66, 0);  expect_at(n, 16'h0602, 8'h11, 1'b1, "marq_off1");
        n = next_at(c + 578, 0); expect_at(n, 16'h040A, 8'h11, 1'b1, "marq_off9_idx0");
        n = next_at(n, 3);       expect_at(n, 16'h0703, 8'h88, 1'b1, "marq_off9_idx3");
        n = next_at(c + 642, 0); expect_at(n, 16'h0501, 8'h11, 1'b1, "marq_wrap");

        // Length load on the same edge as the 11th step; 20 clamps to 16.
        wait_cyc(c + 704);
        c5 = cyc;
        load(5'd20);
        n = next_at(c5 + 2, 0);    expect_at(n, 16'h0501, 8'h11, 1'b1, "len_prio_off0");
        n = next_at(c5 + 66, 0);   expect_at(n, 16'h0602, 8'h11, 1'b1, "len16_step1");
        n = next_at(c5 + 962, 0);  expect_at(n, 16'h0400, 8'h11, 1'b1, "len16_off15");
        n = next_at(c5 + 1026, 0); expect_at(n, 16'h0501, 8'h11, 1'b1, "len16_wrap");
        wait_cyc(n);

        // Blank for 10 cycles while writing buf[1]; back to static mode.
        m = cyc;
        for (int k = 1; k <= 10; k++) expect_at(m + k, 16'h0000, 8'h00, 1'b0, "en_off");
        en     = 1'b0;
        scroll = 1'b0;
        write(4'd1, 8'h7F);
        wait_cyc(m + 10);
        en = 1'b1;
        n = next_at(m + 11, 0); expect_at(n, 16'h0501, 8'h11, 1'b1, "en_back_idx0");
        n = next_at(n, 1);      expect_at(n, 16'h067F, 8'h22, 1'b1, "en_back_idx1");
        wait_cyc(n);
        @(negedge clk);

        if (exp_q.size() > 0) begin
            total += exp_q.size();
            bad   += exp_q.size();
            $display("FAIL drain: %0d expected values never checked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
